wave_lut_scheduler: RTL and testbench

- Time-multiplexes one shared, registered waveform LUT (9-bit address, signed 16-bit data, 1-cycle read latency) across NUM_CH tracker voices.
- On each sample_tick it walks the channels in order, issues each channel's phase-derived LUT address, captures the returned sample, and advances that channel's phase accumulator.
- Sits between the tracker's pattern/config logic (upstream) and the channel mixer (downstream).

---
 rtl/wave_sched_pkg.sv | 22 ++
 rtl/wave_sched_chan_regs.sv | 100 ++++++++++
 rtl/wave_lut_scheduler.sv | 165 ++++++++++++++++
 tb/tb_wave_lut_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_sched_pkg.sv
// Shared types and constants for the wave LUT scheduler.
// Holds waveform-select codes, FSM states and LUT geometry.
package wave_sched_pkg;

    localparam int WAVE_SEL_W = 2;
    typedef logic [WAVE_SEL_W-1:0] wave_sel_t;

    localparam wave_sel_t WAVE_SQUARE = 2'd0;
    localparam wave_sel_t WAVE_SAW    = 2'd1;
    localparam wave_sel_t WAVE_TRI    = 2'd2;
    localparam wave_sel_t WAVE_SINE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sched_state_t;

    localparam int LUT_ADDR_W = 9;
    localparam int LUT_LAT    = 1;

endpackage

// File: rtl/wave_sched_chan_regs.sv
// Per-channel pending/active register file with phase accumulators.
// Ports: cfg_* write pending, commit copies pending to active,
// adv advances phase of rd_ch, rd_* return rd_ch's active state.
module wave_sched_chan_regs
    import wave_sched_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 24,
    parameter int WAVE_W  = 2,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [PHASE_W-1:0]    cfg_inc,
    input  logic [WAVE_W-1:0]     cfg_wave,
    input  logic                  cfg_en,
    input  logic                  cfg_phase_rst,
    input  logic                  commit,
    input  logic                  adv,
    input  logic [CH_W-1:0]       rd_ch,
    output logic [LUT_ADDR_W-1:0] rd_addr,
    output logic [WAVE_W-1:0]     rd_wave,
    output logic                  rd_en
);

    logic [NUM_CH-1:0][PHASE_W-1:0] pend_inc_q, pend_inc_d;
    logic [NUM_CH-1:0][WAVE_W-1:0]  pend_wave_q, pend_wave_d;
    logic [NUM_CH-1:0]              pend_en_q, pend_en_d;
    logic [NUM_CH-1:0]              pend_rst_q, pend_rst_d;

    logic [NUM_CH-1:0][PHASE_W-1:0] inc_q, inc_d;
    logic [NUM_CH-1:0][WAVE_W-1:0]  wave_q, wave_d;
    logic [NUM_CH-1:0]              en_q, en_d;
    logic [NUM_CH-1:0][PHASE_W-1:0] phase_q, phase_d;

    always_comb begin
        pend_inc_d  = pend_inc_q;
        pend_wave_d = pend_wave_q;
        pend_en_d   = pend_en_q;
        pend_rst_d  = pend_rst_q;
        inc_d       = inc_q;
        wave_d      = wave_q;
        en_d        = en_q;
        phase_d     = phase_q;

        if (commit) begin
            inc_d  = pend_inc_q;
            wave_d = pend_wave_q;
            en_d   = pend_en_q;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pend_rst_q[i]) begin
                    phase_d[i] = '0;
                end
            end
            pend_rst_d = '0;
        end

        // A write coinciding with commit lands in pending for next frame.
        if (cfg_we) begin
            pend_inc_d[cfg_ch]  = cfg_inc;
            pend_wave_d[cfg_ch] = cfg_wave;
            pend_en_d[cfg_ch]   = cfg_en;
            pend_rst_d[cfg_ch]  = cfg_phase_rst;
        end

        // Disabled channels keep their slot but hold phase.
        if (adv && en_q[rd_ch]) begin
            phase_d[rd_ch] = phase_q[rd_ch] + inc_q[rd_ch];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_inc_q  <= '0;
            pend_wave_q <= '0;
            pend_en_q   <= '0;
            pend_rst_q  <= '0;
            inc_q       <= '0;
            wave_q      <= '0;
            en_q        <= '0;
            phase_q     <= '0;
        end else begin
            pend_inc_q  <= pend_inc_d;
            pend_wave_q <= pend_wave_d;
            pend_en_q   <= pend_en_d;
            pend_rst_q  <= pend_rst_d;
            inc_q       <= inc_d;
            wave_q      <= wave_d;
            en_q        <= en_d;
            phase_q     <= phase_d;
        end
    end

    assign rd_addr = phase_q[rd_ch][PHASE_W-1 -: LUT_ADDR_W];
    assign rd_wave = wave_q[rd_ch];
    assign rd_en   = en_q[rd_ch];

endmodule

// File: rtl/wave_lut_scheduler.sv
// Time-multiplexes one registered waveform LUT across NUM_CH voices.
// Ports: sample_tick starts a frame, cfg_* stage channel config,
// lut_* drive/return the shared LUT, ch_* stream per-channel samples,
// frame_done marks the last channel, overrun flags early ticks.
module wave_lut_scheduler
    import wave_sched_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 24,
    parameter int WAVE_W  = 2,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [PHASE_W-1:0]    cfg_inc,
    input  logic [WAVE_W-1:0]     cfg_wave,
    input  logic                  cfg_en,
    input  logic                  cfg_phase_rst,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    output logic [WAVE_W-1:0]     lut_wave,
    input  logic signed [15:0]    lut_data,
    output logic signed [15:0]    ch_sample,
    output logic [CH_W-1:0]       ch_idx,
    output logic                  ch_valid,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    sched_state_t          state_q, state_d;
    logic [CH_W-1:0]       k_q, k_d;
    logic [LUT_ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic [WAVE_W-1:0]     lut_wave_q, lut_wave_d;
    logic                  overrun_q, overrun_d;
    logic signed [15:0]    hold_q, hold_d;

    // Tag stage 1 rides with the registered address,
    // stage 2 lines up with lut_data.
    logic                  tag1_v_q, tag1_v_d;
    logic [CH_W-1:0]       tag1_k_q, tag1_k_d;
    logic                  tag1_en_q, tag1_en_d;
    logic                  tag2_v_q, tag2_v_d;
    logic [CH_W-1:0]       tag2_k_q, tag2_k_d;
    logic                  tag2_en_q, tag2_en_d;

    logic                  tick_ok;
    logic                  issue;
    logic [LUT_ADDR_W-1:0] rd_addr;
    logic [WAVE_W-1:0]     rd_wave;
    logic                  rd_en;

    assign tick_ok = sample_tick && (state_q == IDLE);
    assign issue   = (state_q == ISSUE);

    wave_sched_chan_regs #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W),
        .WAVE_W  (WAVE_W)
    ) u_regs (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_inc       (cfg_inc),
        .cfg_wave      (cfg_wave),
        .cfg_en        (cfg_en),
        .cfg_phase_rst (cfg_phase_rst),
        .commit        (tick_ok),
        .adv           (issue),
        .rd_ch         (k_q),
        .rd_addr       (rd_addr),
        .rd_wave       (rd_wave),
        .rd_en         (rd_en)
    );

    assign ch_valid   = tag2_v_q;
    assign ch_idx     = tag2_k_q;
    assign frame_done = tag2_v_q && (tag2_k_q == LAST_CH);
    assign ch_sample  = tag2_v_q ? (tag2_en_q ? lut_data : 16'sd0)
                                 : hold_q;
    assign lut_addr   = lut_addr_q;
    assign lut_wave   = lut_wave_q;
    assign overrun    = overrun_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        lut_addr_d = lut_addr_q;
        lut_wave_d = lut_wave_q;
        overrun_d  = overrun_q;
        hold_d     = ch_sample;

        tag1_v_d   = issue;
        tag1_k_d   = k_q;
        tag1_en_d  = rd_en;
        tag2_v_d   = tag1_v_q;
        tag2_k_d   = tag1_k_q;
        tag2_en_d  = tag1_en_q;

        if (issue) begin
            lut_addr_d = rd_addr;
            lut_wave_d = rd_wave;
        end

        if (sample_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = ISSUE;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_CH) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            lut_addr_q <= '0;
            lut_wave_q <= '0;
            overrun_q  <= 1'b0;
            hold_q     <= '0;
            tag1_v_q   <= 1'b0;
            tag1_k_q   <= '0;
            tag1_en_q  <= 1'b0;
            tag2_v_q   <= 1'b0;
            tag2_k_q   <= '0;
            tag2_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            lut_addr_q <= lut_addr_d;
            lut_wave_q <= lut_wave_d;
            overrun_q  <= overrun_d;
            hold_q     <= hold_d;
            tag1_v_q   <= tag1_v_d;
            tag1_k_q   <= tag1_k_d;
            tag1_en_q  <= tag1_en_d;
            tag2_v_q   <= tag2_v_d;
            tag2_k_q   <= tag2_k_d;
            tag2_en_q  <= tag2_en_d;
        end
    end

endmodule

// File: tb/tb_wave_lut_scheduler.sv
// Scoreboard bench for wave_lut_scheduler with a behavioural LUT.
// Directed frames push expected samples; a monitor pops and compares.
module tb_wave_lut_scheduler;

    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 24;
    localparam int WAVE_W  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                sample_tick = 1'b0;
    logic                cfg_we = 1'b0;
    logic [1:0]          cfg_ch = '0;
    logic [PHASE_W-1:0]  cfg_inc = '0;
    logic [WAVE_W-1:0]   cfg_wave = '0;
    logic                cfg_en = 1'b0;
    logic                cfg_phase_rst = 1'b0;
    logic [8:0]          lut_addr;
    logic [WAVE_W-1:0]   lut_wave;
    logic signed [15:0]  lut_data = '0;
    logic signed [15:0]  ch_sample;
    logic [1:0]          ch_idx;
    logic                ch_valid;
    logic                frame_done;
    logic                overrun;

    wave_lut_scheduler #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W),
        .WAVE_W  (WAVE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_inc       (cfg_inc),
        .cfg_wave      (cfg_wave),
        .cfg_en        (cfg_en),
        .cfg_phase_rst (cfg_phase_rst),
        .lut_addr      (lut_addr),
        .lut_wave      (lut_wave),
        .lut_data      (lut_data),
        .ch_sample     (ch_sample),
        .ch_idx        (ch_idx),
        .ch_valid      (ch_valid),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Square: +full/-full halves. Saw: address in the top bits.
    function automatic logic signed [15:0] lut_fn(input logic [1:0] w,
                                                  input logic [8:0] a);
        logic signed [15:0] r;
        case (w)
            2'd0:    r = a[8] ? 16'sh8001 : 16'sh7FFF;
            2'd1:    r = {a, 7'b0};
            2'd2:    r = {~a, 7'b0};
            default: r = {7'b0, a} ^ 16'h1234;
        endcase
        return r;
    endfunction

    always @(posedge clk) lut_data <= lut_fn(lut_wave, lut_addr);

    logic [PHASE_W-1:0] m_phase [NUM_CH];
    logic [PHASE_W-1:0] m_inc   [NUM_CH];
    logic [1:0]         m_wave  [NUM_CH];
    logic               m_en    [NUM_CH];
    logic [PHASE_W-1:0] p_inc   [NUM_CH];
    logic [1:0]         p_wave  [NUM_CH];
    logic               p_en    [NUM_CH];
    logic               p_rst   [NUM_CH];

    typedef struct {
        int                 idx;
        logic signed [15:0] s;
        bit                 last;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;
    int frames_seen = 0;
    int valids_seen = 0;
    int done_cyc = 0;
    int tick_cyc = 0;
    int f0 = 0;
    int v0 = 0;
    logic signed [15:0] exp_hold = '0;
    logic signed [15:0] last_s [NUM_CH];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ch_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(ch_idx), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ch_idx", 32'(ch_idx), 32'(e.idx));
                    chk("ch_sample", 32'(ch_sample), 32'(e.s));
                    chk("frame_done", 32'(frame_done), 32'(e.last));
                    exp_hold = e.s;
                end
                last_s[ch_idx] = ch_sample;
                valids_seen++;
            end else begin
                chk("hold", 32'(ch_sample), 32'(exp_hold));
                if (frame_done) begin
                    chk("done_wo_valid", 32'(frame_done), 32'd0);
                end
            end
            if (frame_done) begin
                frames_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_phase[i] = '0; m_inc[i] = '0; m_wave[i] = '0; m_en[i] = 0;
            p_inc[i] = '0; p_wave[i] = '0; p_en[i] = 0; p_rst[i] = 0;
            last_s[i] = '0;
        end
        q.delete();
        exp_hold = '0;
    endtask

    task automatic cfg_write(input int ch, input logic [23:0] inc,
                             input logic [1:0] w, input bit en,
                             input bit rst);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_inc = inc;
        cfg_wave = w; cfg_en = en; cfg_phase_rst = rst;
        p_inc[ch] = inc; p_wave[ch] = w; p_en[ch] = en; p_rst[ch] = rst;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_phase_rst = 1'b0;
    endtask

    task automatic start_tick();
        logic [8:0] a;
        for (int i = 0; i < NUM_CH; i++) begin
            m_inc[i] = p_inc[i]; m_wave[i] = p_wave[i]; m_en[i] = p_en[i];
            if (p_rst[i]) m_phase[i] = '0;
            p_rst[i] = 0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            exp_t e;
            a = m_phase[i][PHASE_W-1 -: 9];
            e.idx = i;
            e.s = m_en[i] ? lut_fn(m_wave[i], a) : 16'sd0;
            e.last = (i == NUM_CH - 1);
            q.push_back(e);
            if (m_en[i]) m_phase[i] = m_phase[i] + m_inc[i];
        end
        f0 = frames_seen;
        v0 = valids_seen;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        tick_cyc = cyc;
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 20 && frames_seen == f0; i++) @(negedge clk);
        chk("frame_seen", 32'(frames_seen - f0), 32'd1);
        chk("valid_count", 32'(valids_seen - v0), 32'(NUM_CH));
        chk("queue_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic run_frame();
        start_tick();
        wait_frame();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_lut_addr", 32'(lut_addr), 32'd0);
        chk("rst_lut_wave", 32'(lut_wave), 32'd0);
        chk("rst_ch_sample", 32'(ch_sample), 32'd0);
        chk("rst_ch_idx", 32'(ch_idx), 32'd0);
        chk("rst_ch_valid", 32'(ch_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // All channels disabled.
        run_frame();
        chk("frame_latency", 32'(done_cyc - tick_cyc), 32'd6);

        // Square wave on ch0, address +2 per frame.
        cfg_write(0, 24'h010000, 2'd0, 1'b1, 1'b0);
        for (int f = 0; f <= 256; f++) begin
            run_frame();
            if (f == 0)   chk("sq_f0", 32'(last_s[0]), 32'(16'sh7FFF));
            if (f == 127) chk("sq_f127", 32'(last_s[0]), 32'(16'sh7FFF));
            if (f == 128) chk("sq_f128", 32'(last_s[0]), 32'(16'sh8001));
            if (f == 256) chk("sq_f256", 32'(last_s[0]), 32'(16'sh7FFF));
        end

        // Phase wrap on ch1.
        do_reset();
        cfg_write(1, 24'hFFFFFF, 2'd1, 1'b1, 1'b0);
        run_frame();
        chk("wrap_f1", 32'(last_s[1]), 32'(16'sh0000));
        run_frame();
        chk("wrap_f2", 32'(last_s[1]), 32'(16'shFF80));
        run_frame();
        chk("wrap_f3", 32'(last_s[1]), 32'(16'shFF80));

        // Config write mid-frame, then note-on phase reset.
        do_reset();
        cfg_write(2, 24'h010000, 2'd1, 1'b1, 1'b0);
        run_frame();
        chk("mid_f1", 32'(last_s[2]), 32'(16'sh0000));
        start_tick();
        cfg_write(2, 24'h020000, 2'd1, 1'b1, 1'b0);
        wait_frame();
        chk("mid_f2", 32'(last_s[2]), 32'(16'sh0100));
        run_frame();
        chk("mid_f3", 32'(last_s[2]), 32'(16'sh0200));
        run_frame();
        chk("mid_f4", 32'(last_s[2]), 32'(16'sh0400));
        cfg_write(2, 24'h020000, 2'd1, 1'b1, 1'b1);
        run_frame();
        chk("prst_f5", 32'(last_s[2]), 32'(16'sh0000));
        run_frame();
        chk("prst_f6", 32'(last_s[2]), 32'(16'sh0200));

        // Tick during ISSUE.
        chk("ovr_before", 32'(overrun), 32'd0);
        start_tick();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        wait_frame();
        chk("ovr_set", 32'(overrun), 32'd1);
        run_frame();
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset on the second ISSUE cycle.
        cfg_write(0, 24'h010000, 2'd1, 1'b1, 1'b0);
        f0 = frames_seen;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        model_clear();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(ch_valid), 32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_frame", 32'(frames_seen - f0), 32'd0);
        cfg_write(0, 24'h010000, 2'd1, 1'b1, 1'b0);
        run_frame();
        chk("clean_f1", 32'(last_s[0]), 32'(16'sh0000));
        run_frame();
        chk("clean_f2", 32'(last_s[0]), 32'(16'sh0100));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
